conflict_free_memory_unmap: RTL and testbench
=============================================

// Module: conflict_free_memory_unmap
// PURPOSE
//  Read-return side of the 4-bank conflict-free NTT memory map (N=512).
//  Takes the 4 bank read words with their bank addresses, plus the per-lane bank index.
//  Routes each word back to its butterfly lane and recovers the 9-bit logical address.
//  Flags bank conflicts and feeds the butterfly units through a 2-stage valid/ready pipeline.
// PARAMETERS
//  DATA_W   16  width of one coefficient word
//  CNT_W    16  width of saturating conflict counter
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        synchronous reset, active-low
//  in_valid       in   1        bank read beat valid
//  in_ready       out  1        unit accepts beat this cycle
//  bank_data_k    in   DATA_W   read word from bank k (k=0..3)
//  bank_addr_k    in   7        address bank k was read at (k=0..3)
//  lane_bank_i    in   2        bank index holding lane i's operand (i=0..3)
//  out_valid      out  1        lane beat valid
//  out_ready      in   1        downstream accepts lane beat
//  lane_data_i    out  DATA_W   operand for lane i (i=0..3)
//  lane_addr_i    out  9        recovered logical address for lane i
//  lane_conflict  out  1        beat had >=2 lanes on the same bank
//  conflict_err   out  1        sticky: any conflict since reset
//  conflict_cnt   out  CNT_W    conflicting beats accepted, saturating
// BEHAVIOUR
//  Reset (rst=0 at posedge):
//   - All outputs are 0, including out_valid, lane_*, conflict_err and conflict_cnt.
//   - Both stage valids clear. Beats in flight are dropped.
//   - in_ready is 0 while rst=0.
//  Handshake:
//   - A beat transfers on in_valid&in_ready. Output transfers on out_valid&out_ready.
//   - Inputs are sampled only on transfer.
//   - out_valid is held with lane_* stable until taken.
//  Stage 1 (S1):
//   - On accept, registers per lane i: b=lane_bank_i, a=bank_addr_b, d=bank_data_b.
//   - Registers lane_conflict = OR over pairs i<j of (lane_bank_i==lane_bank_j).
//  Address recovery (in S1):
//   - lane_addr_i[8:2] = a.
//   - lane_addr_i[1:0] = (b - a[6] - a[5:4] - a[3:2] - a[1:0]) mod 4, a 2-bit wraparound sum.
//   - This is the exact inverse of bank = (A[8]+A[7:6]+A[5:4]+A[3:2]+A[1:0]) mod 4.
//  Conflict on a beat:
//   - Lanes sharing a bank all get that bank's data and address. This is not a stall.
//  Stage 2 (S2):
//   - The output register. S1 moves to S2 when S2 is empty or being taken.
//   - in_ready = !s1_v | (s1 moves). This is a combinational path from out_ready, allowed.
//   - Latency: in transfer at cycle t gives out_valid at t+2 when not stalled.
//   - Throughput is 1 beat/cycle when out_ready=1.
//   - Full: S1 and S2 both valid with out_ready=0 gives in_ready=0. There is no overwrite.
//   - Full with out_ready=1 on the same cycle: S2 loads S1 and S1 accepts a new beat in that cycle.
//  Counters:
//   - conflict_cnt increments once per accepted beat with a conflict. It saturates at 2^CNT_W-1.
//   - conflict_err sets on the same event and clears only on reset.
// TESTING
//  1. lanes=A{0,1,2,3}, banks{0,1,2,3}, bank_addr all 0, data{10,11,12,13}, out_ready=1
//     -> after 2 cycles lane_data={10,11,12,13}, lane_addr={0,1,2,3}, lane_conflict=0.
//  2. Logical 5 and 511 (lane_bank={2,1,..}, bank_addr_2=1, bank_addr_1=127)
//     -> lane_addr_0=5, lane_addr_1=511, with 2-bit wraparound checked.
//  3. Back-to-back 8 beats, out_ready low 3 cycles mid-stream
//     -> in_ready drops after 2 held beats, no beat lost or duplicated, order kept.
//  4. lane_bank={1,1,3,0}
//     -> lane_conflict=1, lanes 0/1 get bank1 data, conflict_cnt=1, conflict_err=1.
//     Then 2^CNT_W+2 conflicting beats -> cnt saturates.
//  5. rst=0 with both stages valid
//     -> next cycle out_valid=0, in_ready=0, counters=0. First beat after release has latency 2.
//  6. Random logical addresses encoded by the forward map, fed back
//     -> recovered lane_addr equals original for all 512 addresses.

Source files
------------

// File: rtl/conflict_free_memory_unmap.sv
// Read-return side of the 4-bank conflict-free NTT memory map (N=512).
// Routes bank words back to butterfly lanes, recovers logical addresses and flags bank conflicts.
module conflict_free_memory_unmap #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] bank_data_0,
  input  logic [DATA_W-1:0] bank_data_1,
  input  logic [DATA_W-1:0] bank_data_2,
  input  logic [DATA_W-1:0] bank_data_3,
  input  logic [6:0]        bank_addr_0,
  input  logic [6:0]        bank_addr_1,
  input  logic [6:0]        bank_addr_2,
  input  logic [6:0]        bank_addr_3,
  input  logic [1:0]        lane_bank_0,
  input  logic [1:0]        lane_bank_1,
  input  logic [1:0]        lane_bank_2,
  input  logic [1:0]        lane_bank_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] lane_data_0,
  output logic [DATA_W-1:0] lane_data_1,
  output logic [DATA_W-1:0] lane_data_2,
  output logic [DATA_W-1:0] lane_data_3,
  output logic [8:0]        lane_addr_0,
  output logic [8:0]        lane_addr_1,
  output logic [8:0]        lane_addr_2,
  output logic [8:0]        lane_addr_3,
  output logic              lane_conflict,
  output logic              conflict_err,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned BANK_AW   = 7;
  localparam int unsigned LOG_AW    = 9;

  logic [DATA_W-1:0]  w_bank_data [NUM_LANES];
  logic [BANK_AW-1:0] w_bank_addr [NUM_LANES];
  logic [1:0]         w_lane_bank [NUM_LANES];
  logic [DATA_W-1:0]  w_sel_data  [NUM_LANES];
  logic [LOG_AW-1:0]  w_sel_addr  [NUM_LANES];
  logic               w_conflict;
  logic               w_in_fire;
  logic               w_s1_move;

  logic               r_s1_v;
  logic [DATA_W-1:0]  r_s1_data [NUM_LANES];
  logic [LOG_AW-1:0]  r_s1_addr [NUM_LANES];
  logic               r_s1_conf;
  logic               r_s2_v;
  logic [DATA_W-1:0]  r_s2_data [NUM_LANES];
  logic [LOG_AW-1:0]  r_s2_addr [NUM_LANES];
  logic               r_s2_conf;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  assign w_bank_data = '{bank_data_0, bank_data_1, bank_data_2, bank_data_3};
  assign w_bank_addr = '{bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3};
  assign w_lane_bank = '{lane_bank_0, lane_bank_1, lane_bank_2, lane_bank_3};

  // Lane crossbar plus inverse of bank = (A[8]+A[7:6]+A[5:4]+A[3:2]+A[1:0]) mod 4
  always_comb begin
    logic [BANK_AW-1:0] v_a;
    logic [1:0]         v_low;
    v_a   = '0;
    v_low = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      v_a           = w_bank_addr[w_lane_bank[i]];
      v_low         = 2'(w_lane_bank[i] - {1'b0, v_a[6]} - v_a[5:4] - v_a[3:2] - v_a[1:0]);
      w_sel_data[i] = w_bank_data[w_lane_bank[i]];
      w_sel_addr[i] = {v_a, v_low};
    end
  end

  assign w_conflict = (lane_bank_0 == lane_bank_1) | (lane_bank_0 == lane_bank_2) |
                      (lane_bank_0 == lane_bank_3) | (lane_bank_1 == lane_bank_2) |
                      (lane_bank_1 == lane_bank_3) | (lane_bank_2 == lane_bank_3);

  // S1 advances whenever the output register is empty or being drained this cycle
  assign w_s1_move = r_s1_v & (~r_s2_v | out_ready);
  assign in_ready  = rst & (~r_s1_v | w_s1_move);
  assign w_in_fire = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_v    <= 1'b0;
      r_s1_conf <= 1'b0;
      r_s2_v    <= 1'b0;
      r_s2_conf <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_s1_data[i] <= '0;
        r_s1_addr[i] <= '0;
        r_s2_data[i] <= '0;
        r_s2_addr[i] <= '0;
      end
    end else begin
      if (w_in_fire) begin
        r_s1_v    <= 1'b1;
        r_s1_conf <= w_conflict;
        for (int i = 0; i < NUM_LANES; i++) begin
          r_s1_data[i] <= w_sel_data[i];
          r_s1_addr[i] <= w_sel_addr[i];
        end
      end else if (w_s1_move) begin
        r_s1_v <= 1'b0;
      end

      if (w_s1_move) begin
        r_s2_v    <= 1'b1;
        r_s2_conf <= r_s1_conf;
        for (int i = 0; i < NUM_LANES; i++) begin
          r_s2_data[i] <= r_s1_data[i];
          r_s2_addr[i] <= r_s1_addr[i];
        end
      end else if (out_ready) begin
        r_s2_v <= 1'b0;
      end

      // Conflict statistics count accepted beats, not delivered ones
      if (w_in_fire && w_conflict) begin
        r_err <= 1'b1;
        if (r_cnt != {CNT_W{1'b1}}) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid     = r_s2_v;
  assign lane_conflict = r_s2_conf;
  assign conflict_err  = r_err;
  assign conflict_cnt  = r_cnt;
  assign lane_data_0   = r_s2_data[0];
  assign lane_data_1   = r_s2_data[1];
  assign lane_data_2   = r_s2_data[2];
  assign lane_data_3   = r_s2_data[3];
  assign lane_addr_0   = r_s2_addr[0];
  assign lane_addr_1   = r_s2_addr[1];
  assign lane_addr_2   = r_s2_addr[2];
  assign lane_addr_3   = r_s2_addr[3];

endmodule

// File: tb/tb_conflict_free_memory_unmap.sv
// Directed bench for conflict_free_memory_unmap: routing, address recovery,
// backpressure, conflict counting/saturation, reset flush and full address sweep.
module tb_conflict_free_memory_unmap;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] bank_data_0, bank_data_1, bank_data_2, bank_data_3;
  logic [6:0]        bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3;
  logic [1:0]        lane_bank_0, lane_bank_1, lane_bank_2, lane_bank_3;
  logic [DATA_W-1:0] lane_data_0, lane_data_1, lane_data_2, lane_data_3;
  logic [8:0]        lane_addr_0, lane_addr_1, lane_addr_2, lane_addr_3;
  logic              lane_conflict, conflict_err;
  logic [CNT_W-1:0]  conflict_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conflict_free_memory_unmap #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .bank_data_0(bank_data_0), .bank_data_1(bank_data_1),
    .bank_data_2(bank_data_2), .bank_data_3(bank_data_3),
    .bank_addr_0(bank_addr_0), .bank_addr_1(bank_addr_1),
    .bank_addr_2(bank_addr_2), .bank_addr_3(bank_addr_3),
    .lane_bank_0(lane_bank_0), .lane_bank_1(lane_bank_1),
    .lane_bank_2(lane_bank_2), .lane_bank_3(lane_bank_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .lane_data_0(lane_data_0), .lane_data_1(lane_data_1),
    .lane_data_2(lane_data_2), .lane_data_3(lane_data_3),
    .lane_addr_0(lane_addr_0), .lane_addr_1(lane_addr_1),
    .lane_addr_2(lane_addr_2), .lane_addr_3(lane_addr_3),
    .lane_conflict(lane_conflict), .conflict_err(conflict_err),
    .conflict_cnt(conflict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [1:0] b0, input logic [1:0] b1,
                           input logic [1:0] b2, input logic [1:0] b3);
    lane_bank_0 = b0; lane_bank_1 = b1; lane_bank_2 = b2; lane_bank_3 = b3;
  endtask

  task automatic set_banks(input logic [15:0] d0, input logic [15:0] d1,
                           input logic [15:0] d2, input logic [15:0] d3,
                           input logic [6:0] a0, input logic [6:0] a1,
                           input logic [6:0] a2, input logic [6:0] a3);
    bank_data_0 = d0; bank_data_1 = d1; bank_data_2 = d2; bank_data_3 = d3;
    bank_addr_0 = a0; bank_addr_1 = a1; bank_addr_2 = a2; bank_addr_3 = a3;
  endtask

  // Forward map used to build the address sweep independently of the DUT inverse
  function automatic logic [1:0] fwd_bank(input logic [8:0] a);
    return 2'({1'b0, a[8]} + a[7:6] + a[5:4] + a[3:2] + a[1:0]);
  endfunction

  initial begin
    int k, n_out, n_stall, mism;
    logic [8:0] la;
    logic [1:0] bk;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_lanes(2'd0, 2'd1, 2'd2, 2'd3);
    set_banks(16'd0, 16'd0, 16'd0, 16'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);
    chk("rst_err", 32'(conflict_err), 32'd0);
    chk("rst_lane_data0", 32'(lane_data_0), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Identity routing, latency 2
    set_banks(16'd10, 16'd11, 16'd12, 16'd13, 7'd0, 7'd0, 7'd0, 7'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_lat1_valid", 32'(out_valid), 32'd0);
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_d0", 32'(lane_data_0), 32'd10);
    chk("t1_d1", 32'(lane_data_1), 32'd11);
    chk("t1_d2", 32'(lane_data_2), 32'd12);
    chk("t1_d3", 32'(lane_data_3), 32'd13);
    chk("t1_a0", 32'(lane_addr_0), 32'd0);
    chk("t1_a1", 32'(lane_addr_1), 32'd1);
    chk("t1_a2", 32'(lane_addr_2), 32'd2);
    chk("t1_a3", 32'(lane_addr_3), 32'd3);
    chk("t1_conf", 32'(lane_conflict), 32'd0);
    step();
    chk("t1_drain", 32'(out_valid), 32'd0);

    // Logical 5, 511, 510 (wraparound) and 3
    set_lanes(2'd2, 2'd1, 2'd0, 2'd3);
    set_banks(16'hA0, 16'hA1, 16'hA2, 16'hA3, 7'd127, 7'd127, 7'd1, 7'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t2_a0", 32'(lane_addr_0), 32'd5);
    chk("t2_a1", 32'(lane_addr_1), 32'd511);
    chk("t2_a2_wrap", 32'(lane_addr_2), 32'd510);
    chk("t2_a3", 32'(lane_addr_3), 32'd3);
    chk("t2_d0", 32'(lane_data_0), 32'hA2);
    chk("t2_d2", 32'(lane_data_2), 32'hA0);
    step();

    // 8 back-to-back beats, out_ready low for cycles 4..6
    set_lanes(2'd0, 2'd1, 2'd2, 2'd3);
    set_banks(16'd0, 16'd0, 16'd0, 16'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    k = 0; n_out = 0; n_stall = 0;
    for (int cyc = 0; cyc < 40 && n_out < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      if (k < 8) begin
        in_valid = 1'b1;
        bank_data_0 = 16'(100 + k);
        bank_data_3 = 16'(200 + k);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        chk("t3_order_d0", 32'(lane_data_0), 32'(100 + n_out));
        chk("t3_order_d3", 32'(lane_data_3), 32'(200 + n_out));
        n_out++;
      end
      if (in_valid && in_ready) k++;
      if (in_valid && !in_ready) n_stall++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("t3_sent", 32'(k), 32'd8);
    chk("t3_recv", 32'(n_out), 32'd8);
    chk("t3_stall_cycles", 32'(n_stall), 32'd3);
    step();
    chk("t3_empty", 32'(out_valid), 32'd0);
    chk("t3_no_conf", 32'(conflict_cnt), 32'd0);

    // Conflict beat: lanes 0/1 share bank 1 at bank address 3 -> logical 14
    set_lanes(2'd1, 2'd1, 2'd3, 2'd0);
    set_banks(16'h11, 16'h55, 16'h22, 16'h33, 7'd0, 7'd3, 7'd0, 7'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t4_conf", 32'(lane_conflict), 32'd1);
    chk("t4_d0", 32'(lane_data_0), 32'h55);
    chk("t4_d1", 32'(lane_data_1), 32'h55);
    chk("t4_a0", 32'(lane_addr_0), 32'd14);
    chk("t4_a1", 32'(lane_addr_1), 32'd14);
    chk("t4_d2", 32'(lane_data_2), 32'h33);
    chk("t4_cnt", 32'(conflict_cnt), 32'd1);
    chk("t4_err", 32'(conflict_err), 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 13; i++) step();
    chk("t4_cnt14", 32'(conflict_cnt), 32'd14);
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    chk("t4_cnt_sat", 32'(conflict_cnt), 32'd15);
    step(); step(); step();
    chk("t4_err_sticky", 32'(conflict_err), 32'd1);

    // Reset with both stages full
    set_lanes(2'd0, 2'd1, 2'd2, 2'd3);
    set_banks(16'd7, 16'd8, 16'd9, 16'd6, 7'd0, 7'd0, 7'd0, 7'd0);
    out_ready = 1'b0; in_valid = 1'b1;
    step(); step();
    chk("t5_full_valid", 32'(out_valid), 32'd1);
    chk("t5_full_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd0);
    chk("t5_cnt", 32'(conflict_cnt), 32'd0);
    chk("t5_err", 32'(conflict_err), 32'd0);
    chk("t5_d0", 32'(lane_data_0), 32'd0);
    rst = 1'b1; out_ready = 1'b1;
    bank_data_0 = 16'd77;
    step();
    in_valid = 1'b0;
    chk("t5_lat1", 32'(out_valid), 32'd0);
    step();
    chk("t5_lat2", 32'(out_valid), 32'd1);
    chk("t5_data", 32'(lane_data_0), 32'd77);
    step(); step();

    // Full 512-address sweep through lane 0, one beat per cycle
    mism = 0;
    set_lanes(2'd0, 2'd1, 2'd2, 2'd3);
    set_banks(16'd0, 16'd0, 16'd0, 16'd0, 7'd0, 7'd0, 7'd0, 7'd0);
    for (int c = 0; c < 514; c++) begin
      if (c >= 2) begin
        la = 9'(c - 2);
        if (!(out_valid === 1'b1 && lane_addr_0 === la)) mism++;
      end
      if (c < 512) begin
        la = 9'(c);
        bk = fwd_bank(la);
        set_banks(16'd0, 16'd0, 16'd0, 16'd0, 7'd0, 7'd0, 7'd0, 7'd0);
        lane_bank_0 = bk;
        case (bk)
          2'd0: bank_addr_0 = la[8:2];
          2'd1: bank_addr_1 = la[8:2];
          2'd2: bank_addr_2 = la[8:2];
          default: bank_addr_3 = la[8:2];
        endcase
        lane_bank_1 = bk + 2'd1; lane_bank_2 = bk + 2'd2; lane_bank_3 = bk + 2'd3;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    chk("t6_sweep_mismatches", 32'(mism), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
